iir_wb_streamer: RTL and testbench

Streaming front-end and Wishbone master that drives the IIR filter register block. Accepts input samples on a valid/ready stream and buffers them in a small FIFO. For each sample it writes X (0x00), waits for the filter pipeline to settle, reads Y (0x04), then reads STATUS (0x08). It emits the filtered sample with its overflow flag on a valid/ready output stream.

---
 rtl/iir_wb_streamer.sv | 239 +++++++++++++++++++++++
 tb/tb_iir_wb_streamer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_wb_streamer.sv
// iir_wb_streamer: stream front-end and Wishbone master for the IIR register block.
// Each buffered sample is written to X, the filter is given time to settle,
// then Y and STATUS are read back and emitted on the output stream.
module iir_wb_streamer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  en,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_ovf,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic                  wbm_we_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    input  logic                  wbm_ack_i,
    output logic                  bus_err,
    output logic [15:0]           sample_cnt
);

    localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW         = PW + 1;
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int TMO_EFF    = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;

    localparam logic [ADDR_WIDTH-1:0] ADR_X  = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] ADR_Y  = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] ADR_ST = ADDR_WIDTH'(8'h08);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_X,
        ST_WAIT,
        ST_RD_Y,
        ST_GAP,
        ST_RD_ST,
        ST_OUT
    } state_t;

    state_t state_q;

    // input FIFO
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  s_ready_q;
    logic                  push;
    logic                  pop;

    // bus master / output registers
    logic [DATA_WIDTH-1:0] x_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_o_q;
    logic                  we_q;
    logic                  stb_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_ovf_q;
    logic                  m_valid_q;
    logic                  bus_err_q;
    logic [15:0]           sample_cnt_q;
    logic [31:0]           settle_cnt_q;
    logic [31:0]           tmo_cnt_q;
    logic                  ack_seen;
    logic                  tmo_hit;

    assign push     = s_valid && s_ready_q;
    assign pop      = (state_q == ST_IDLE) && en && (count_q != '0);
    assign ack_seen = stb_q && wbm_ack_i;
    assign tmo_hit  = stb_q && !wbm_ack_i && (tmo_cnt_q == 32'(TMO_EFF - 1));

    // next FIFO occupancy from this cycle's push/pop pair
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q   <= count_d;
            s_ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    // sequencer: bus accesses, read-data capture, output handshake, error flag
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            adr_q        <= '0;
            dat_o_q      <= '0;
            we_q         <= 1'b0;
            stb_q        <= 1'b0;
            m_data_q     <= '0;
            m_ovf_q      <= 1'b0;
            m_valid_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            sample_cnt_q <= '0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            // stb is always low for at least one cycle before rising, so the
            // counter is already zero when a new access starts
            if (stb_q && !wbm_ack_i) begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
            end else begin
                tmo_cnt_q <= '0;
            end

            if (tmo_hit) begin
                bus_err_q <= 1'b1;
            end else if (clr_err) begin
                bus_err_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        x_q     <= mem_q[rd_ptr_q];
                        dat_o_q <= mem_q[rd_ptr_q];
                        adr_q   <= ADR_X;
                        we_q    <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= ST_WR_X;
                    end
                end
                ST_WR_X: begin
                    if (ack_seen) begin
                        stb_q        <= 1'b0;
                        we_q         <= 1'b0;
                        settle_cnt_q <= 32'(SETTLE_EFF - 1);
                        state_q      <= ST_WAIT;
                    end else if (tmo_hit) begin
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (settle_cnt_q == '0) begin
                        adr_q   <= ADR_Y;
                        we_q    <= 1'b0;
                        stb_q   <= 1'b1;
                        state_q <= ST_RD_Y;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 32'd1;
                    end
                end
                ST_RD_Y: begin
                    if (ack_seen) begin
                        m_data_q <= wbm_dat_i;
                        stb_q    <= 1'b0;
                        state_q  <= ST_GAP;
                    end else if (tmo_hit) begin
                        stb_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    adr_q   <= ADR_ST;
                    we_q    <= 1'b0;
                    stb_q   <= 1'b1;
                    state_q <= ST_RD_ST;
                end
                ST_RD_ST: begin
                    if (ack_seen) begin
                        m_ovf_q   <= wbm_dat_i[3];
                        stb_q     <= 1'b0;
                        m_valid_q <= 1'b1;
                        state_q   <= ST_OUT;
                    end else if (tmo_hit) begin
                        stb_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_q    <= 1'b0;
                        sample_cnt_q <= sample_cnt_q + 16'd1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    stb_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign m_data     = m_data_q;
    assign m_ovf      = m_ovf_q;
    assign m_valid    = m_valid_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_o_q;
    assign wbm_we_o   = we_q;
    assign wbm_stb_o  = stb_q;
    assign wbm_cyc_o  = stb_q;
    assign bus_err    = bus_err_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_iir_wb_streamer.sv
// Directed bench for iir_wb_streamer with a simple Wishbone slave stand-in:
// Y reads return last written X + 0x1000, STATUS reads return status_val.
module tb_iir_wb_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        clr_err = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_ovf;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        bus_err;
    logic [15:0] sample_cnt;

    // slave model state
    logic        noack = 1'b0;
    logic [31:0] status_val = '0;
    logic [31:0] y_val = '0;
    logic [7:0]  log_adr [0:255];
    logic        log_we  [0:255];
    logic [31:0] log_dat [0:255];
    int          log_n = 0;

    int n_checks = 0;
    int n_errors = 0;

    iir_wb_streamer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .FIFO_DEPTH(4),
        .SETTLE_CYCLES(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .en(en),
        .clr_err(clr_err),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_data(m_data),
        .m_ovf(m_ovf),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i),
        .wbm_we_o(we),
        .wbm_stb_o(stb),
        .wbm_cyc_o(cyc),
        .wbm_ack_i(ack),
        .bus_err(bus_err),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // slave: acks one cycle after stb, logs each access once
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            ack <= stb && !ack && !noack;
            if (stb && !ack && !noack) begin
                if (log_n < 256) begin
                    log_adr[log_n] <= adr;
                    log_we[log_n]  <= we;
                    log_dat[log_n] <= dat_o;
                end
                log_n <= log_n + 1;
                if (we) y_val <= dat_o + 32'h0000_1000;
            end
        end
    end

    assign dat_i = (adr == 8'h04) ? y_val :
                   (adr == 8'h08) ? status_val : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        en = 1'b1;
        clr_err = 1'b0;
        noack = 1'b0;
        status_val = '0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic push_one(input logic [31:0] d);
        s_data = d;
        s_valid = 1'b1;
        tick;
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!m_valid && n < 80) begin
            tick;
            n++;
        end
        chk("wait_valid", {31'd0, m_valid}, 32'd1);
    endtask

    task automatic wait_stb(input logic [7:0] a);
        int n;
        n = 0;
        while (!(stb && adr == a) && n < 80) begin
            tick;
            n++;
        end
        chk("wait_stb", {31'd0, stb}, 32'd1);
    endtask

    task automatic accept;
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
    endtask

    initial begin
        int n;
        int hi;
        int base;
        int pushed;
        int nout;
        int cyc_i;
        logic acc;
        logic hs;
        logic saw;
        logic full_checked;
        logic [31:0] d;
        logic [31:0] din [0:5];
        logic [31:0] outs [0:5];

        din[0] = 32'h1111_0001; din[1] = 32'h2222_0002; din[2] = 32'h3333_0003;
        din[3] = 32'h4444_0004; din[4] = 32'h5555_0005; din[5] = 32'h6666_0006;

        // ---- reset values
        do_reset;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_bus", {25'd0, stb, cyc, we, bus_err, m_ovf, 2'b00}, 32'd0);
        chk("rst_adr_dat", {24'd0, adr} | dat_o, 32'd0);
        chk("rst_cnt", {16'd0, sample_cnt}, 32'd0);

        // ---- single sample: latency and bus sequence
        base = log_n;
        push_one(32'h0010_0000);
        n = 0;
        while (!m_valid && n < 40) begin
            tick;
            n++;
        end
        chk("latency", n, 32'd12);
        chk("n_access", log_n - base, 32'd3);
        chk("wr_adr", {24'd0, log_adr[base]}, 32'h00);
        chk("wr_we", {31'd0, log_we[base]}, 32'd1);
        chk("wr_dat", log_dat[base], 32'h0010_0000);
        chk("rdy_adr", {24'd0, log_adr[base+1]}, 32'h04);
        chk("rdy_we", {31'd0, log_we[base+1]}, 32'd0);
        chk("rdst_adr", {24'd0, log_adr[base+2]}, 32'h08);
        chk("rdst_we", {31'd0, log_we[base+2]}, 32'd0);
        chk("single_data", m_data, 32'h0010_1000);
        chk("single_ovf", {31'd0, m_ovf}, 32'd0);
        chk("cnt_before_hs", {16'd0, sample_cnt}, 32'd0);
        accept;
        chk("valid_drop", {31'd0, m_valid}, 32'd0);
        chk("cnt_after_hs", {16'd0, sample_cnt}, 32'd1);

        // ---- back-pressure: 6 samples with m_ready low, then released
        do_reset;
        pushed = 0;
        full_checked = 1'b0;
        for (cyc_i = 0; cyc_i < 40; cyc_i++) begin
            if (pushed < 6) begin
                s_valid = 1'b1;
                s_data = din[pushed];
            end else begin
                s_valid = 1'b0;
            end
            acc = s_valid && s_ready;
            tick;
            if (acc) pushed++;
            if (pushed == 5 && !full_checked) begin
                chk("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
                full_checked = 1'b1;
            end
        end
        chk("bp_pushed", pushed, 32'd5);
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_data0", m_data, din[0] + 32'h1000);
        repeat (5) tick;
        chk("bp_data_stable", m_data, din[0] + 32'h1000);
        m_ready = 1'b1;
        nout = 0;
        for (cyc_i = 0; cyc_i < 200 && nout < 6; cyc_i++) begin
            if (pushed < 6) begin
                s_valid = 1'b1;
                s_data = din[pushed];
            end else begin
                s_valid = 1'b0;
            end
            acc = s_valid && s_ready;
            hs = m_valid && m_ready;
            d = m_data;
            tick;
            if (acc) pushed++;
            if (hs) begin
                outs[nout] = d;
                nout++;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("bp_nout", nout, 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < nout) chk("bp_order", outs[i], din[i] + 32'h1000);
        end
        chk("bp_cnt", {16'd0, sample_cnt}, 32'd6);

        // ---- en low blocks the pop
        do_reset;
        en = 1'b0;
        push_one(32'h0000_00AA);
        saw = 1'b0;
        repeat (20) begin
            tick;
            if (stb) saw = 1'b1;
        end
        chk("en_low_no_stb", {31'd0, saw}, 32'd0);
        en = 1'b1;
        wait_valid(n);
        chk("en_data", m_data, 32'h0000_10AA);
        accept;

        // ---- overflow flag from STATUS bit 3 only
        status_val = 32'h0000_0008;
        push_one(32'h7FFF_FFFF);
        wait_valid(n);
        chk("ovf_data", m_data, 32'h8000_0FFF);
        chk("ovf_set", {31'd0, m_ovf}, 32'd1);
        accept;
        status_val = 32'h0000_0007;
        push_one(32'h0000_0005);
        wait_valid(n);
        chk("ovf_clear_data", m_data, 32'h0000_1005);
        chk("ovf_clear", {31'd0, m_ovf}, 32'd0);
        accept;
        chk("ovf_cnt", {16'd0, sample_cnt}, 32'd3);

        // ---- timeout: slave never acks
        do_reset;
        noack = 1'b1;
        push_one(32'h0000_1234);
        wait_stb(8'h00);
        hi = 0;
        while (stb && hi < 40) begin
            tick;
            hi++;
        end
        chk("tmo_stb_cycles", hi, 32'd16);
        chk("tmo_cyc_low", {31'd0, cyc}, 32'd0);
        chk("tmo_bus_err", {31'd0, bus_err}, 32'd1);
        saw = 1'b0;
        repeat (20) begin
            tick;
            if (m_valid || stb) saw = 1'b1;
        end
        chk("tmo_discard", {31'd0, saw}, 32'd0);
        chk("tmo_cnt", {16'd0, sample_cnt}, 32'd0);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("clr_err", {31'd0, bus_err}, 32'd0);
        // clear on the same edge as a new timeout: set wins
        push_one(32'h0000_5678);
        wait_stb(8'h00);
        hi = 0;
        while (stb && hi < 40) begin
            if (hi == 15) clr_err = 1'b1;
            tick;
            clr_err = 1'b0;
            hi++;
        end
        chk("tmo2_stb_cycles", hi, 32'd16);
        chk("set_beats_clr", {31'd0, bus_err}, 32'd1);
        noack = 1'b0;
        push_one(32'h0000_0020);
        wait_valid(n);
        chk("tmo_recover", m_data, 32'h0000_1020);
        chk("tmo_err_sticky", {31'd0, bus_err}, 32'd1);
        accept;

        // ---- async reset during the Y read
        do_reset;
        push_one(32'h0000_0044);
        wait_valid(n);
        accept;
        push_one(32'h0000_0055);
        wait_stb(8'h04);
        rst = 1'b1;
        #1;
        chk("amid_stb", {30'd0, stb, cyc}, 32'd0);
        chk("amid_m_data", m_data, 32'd0);
        chk("amid_cnt", {16'd0, sample_cnt}, 32'd0);
        chk("amid_misc", {28'd0, m_valid, we, bus_err, m_ovf}, 32'd0);
        chk("amid_s_ready", {31'd0, s_ready}, 32'd1);
        tick;
        rst = 1'b0;
        tick;
        push_one(32'h0000_0066);
        wait_valid(n);
        chk("amid_after", m_data, 32'h0000_1066);
        accept;
        chk("amid_after_cnt", {16'd0, sample_cnt}, 32'd1);

        // ---- sample_cnt wrap
        do_reset;
        dut.sample_cnt_q = 16'hFFFF;
        push_one(32'h0000_0077);
        wait_valid(n);
        chk("wrap_hold", {16'd0, sample_cnt}, 32'h0000_FFFF);
        accept;
        chk("wrap_zero", {16'd0, sample_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
